// File: rtl/rs_issue_if.sv
// Issue-stage bus bundle: instruction-queue head, ROB allocation, regfile read
// and rename, RS busy feedback, and the registered RS issue port.
interface rs_issue_if #(
  parameter int RS_SIZE   = 16,
  parameter int RS_IDX_W  = 4,
  parameter int ROB_IDX_W = 4,
  parameter int IMM_W     = 32,
  parameter int ID_W      = 6,
  parameter int WORD_W    = 32
);
  // global control
  logic                 rdy_in;
  logic                 clear_branch_in;
  // instruction queue head
  logic                 iq_valid_in;
  logic [ID_W-1:0]      iq_instr_id_in;
  logic [IMM_W-1:0]     iq_imm_in;
  logic [4:0]           iq_rs1_in;
  logic [4:0]           iq_rs2_in;
  logic [4:0]           iq_rd_in;
  logic [WORD_W-1:0]    iq_pc_in;
  logic                 iq_pop_out;
  // RS and ROB status / allocation
  logic [RS_SIZE-1:0]   rs_busy_status_in;
  logic                 rob_full_in;
  logic [ROB_IDX_W-1:0] rob_free_tag_in;
  logic                 rob_alloc_en_out;
  // regfile read and rename
  logic [WORD_W-1:0]    reg_rs1_val_in;
  logic [WORD_W-1:0]    reg_rs2_val_in;
  logic [ROB_IDX_W-1:0] reg_rs1_tag_in;
  logic [ROB_IDX_W-1:0] reg_rs2_tag_in;
  logic                 rename_en_out;
  logic [4:0]           rename_rd_out;
  logic [ROB_IDX_W-1:0] rename_tag_out;
  // registered RS issue port
  logic                 issue_to_rs_en_out;
  logic [RS_IDX_W-1:0]  rs_pos_out;
  logic [ROB_IDX_W-1:0] rob_pos_out;
  logic [ID_W-1:0]      instr_id_out;
  logic [IMM_W-1:0]     imm_out;
  logic [WORD_W-1:0]    pc_out;
  logic [4:0]           rd_out;
  logic [WORD_W-1:0]    rs1_reg_out;
  logic [WORD_W-1:0]    rs2_reg_out;
  logic [ROB_IDX_W-1:0] rs1_tag_out;
  logic [ROB_IDX_W-1:0] rs2_tag_out;

  // issue stage side
  modport master (
    input  rdy_in, clear_branch_in,
    input  iq_valid_in, iq_instr_id_in, iq_imm_in, iq_rs1_in, iq_rs2_in, iq_rd_in, iq_pc_in,
    output iq_pop_out,
    input  rs_busy_status_in, rob_full_in, rob_free_tag_in,
    output rob_alloc_en_out,
    input  reg_rs1_val_in, reg_rs2_val_in, reg_rs1_tag_in, reg_rs2_tag_in,
    output rename_en_out, rename_rd_out, rename_tag_out,
    output issue_to_rs_en_out, rs_pos_out, rob_pos_out, instr_id_out, imm_out, pc_out, rd_out,
    output rs1_reg_out, rs2_reg_out, rs1_tag_out, rs2_tag_out
  );

  // environment side (queue, ROB, regfile, RS)
  modport slave (
    output rdy_in, clear_branch_in,
    output iq_valid_in, iq_instr_id_in, iq_imm_in, iq_rs1_in, iq_rs2_in, iq_rd_in, iq_pc_in,
    input  iq_pop_out,
    output rs_busy_status_in, rob_full_in, rob_free_tag_in,
    input  rob_alloc_en_out,
    output reg_rs1_val_in, reg_rs2_val_in, reg_rs1_tag_in, reg_rs2_tag_in,
    input  rename_en_out, rename_rd_out, rename_tag_out,
    input  issue_to_rs_en_out, rs_pos_out, rob_pos_out, instr_id_out, imm_out, pc_out, rd_out,
    input  rs1_reg_out, rs2_reg_out, rs1_tag_out, rs2_tag_out
  );
endinterface

// File: rtl/rs_issue.sv
// ALU/branch issue stage: pops the IQ head, picks the lowest free RS slot
// (masking the slot issued last cycle, which the RS busy vector does not yet
// show), allocates a ROB tag, renames rd and drives a registered RS issue port.
module rs_issue #(
  parameter int RS_SIZE   = 16,
  parameter int RS_IDX_W  = 4,
  parameter int ROB_IDX_W = 4,
  parameter int IMM_W     = 32,
  parameter int ID_W      = 6,
  parameter int WORD_W    = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  rs_issue_if.master   bus
);

  logic                 issue_q;
  logic [RS_IDX_W-1:0]  rs_pos_q;
  logic [ROB_IDX_W-1:0] rob_pos_q;
  logic [ID_W-1:0]      instr_id_q;
  logic [IMM_W-1:0]     imm_q;
  logic [WORD_W-1:0]    pc_q;
  logic [4:0]           rd_q;
  logic [WORD_W-1:0]    rs1_val_q, rs2_val_q;
  logic [ROB_IDX_W-1:0] rs1_tag_q, rs2_tag_q;

  logic [RS_SIZE-1:0]   pend_mask;
  logic [RS_SIZE-1:0]   free;
  logic [RS_IDX_W-1:0]  sel;
  logic                 has_free;
  logic                 accept;

  // Free-slot search: last cycle's issue is still invisible in the busy vector.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pend_mask = '0;
    sel       = '0;
    if (issue_q) pend_mask[rs_pos_q] = 1'b1;
    free     = ~bus.rs_busy_status_in & ~pend_mask;
    has_free = |free;
    // scan downward so the lowest free index wins
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (free[i]) sel = i[RS_IDX_W-1:0];
    end
    accept = bus.rdy_in && !rst_in && !bus.clear_branch_in && bus.iq_valid_in &&
             !bus.rob_full_in && has_free;
  end

  assign bus.iq_pop_out       = accept;
  assign bus.rob_alloc_en_out = accept;
  assign bus.rename_en_out    = accept && (bus.iq_rd_in != 5'd0);
  assign bus.rename_rd_out    = rst_in ? 5'd0 : bus.iq_rd_in;
  assign bus.rename_tag_out   = rst_in ? '0 : bus.rob_free_tag_in;

  // Issue port register: strobe follows accept; payload captured only on accept.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst_in) begin
      issue_q    <= 1'b0;
      rs_pos_q   <= '0;
      rob_pos_q  <= '0;
      instr_id_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      rs1_tag_q  <= '0;
      rs2_tag_q  <= '0;
    end else if (bus.rdy_in) begin
      issue_q <= accept;
      if (accept) begin
        rs_pos_q   <= sel;
        rob_pos_q  <= bus.rob_free_tag_in;
        instr_id_q <= bus.iq_instr_id_in;
        imm_q      <= bus.iq_imm_in;
        pc_q       <= bus.iq_pc_in;
        rd_q       <= bus.iq_rd_in;
        // x0 is hardwired zero and never has a producer
        rs1_val_q  <= (bus.iq_rs1_in == 5'd0) ? '0 : bus.reg_rs1_val_in;
        rs1_tag_q  <= (bus.iq_rs1_in == 5'd0) ? '0 : bus.reg_rs1_tag_in;
        rs2_val_q  <= (bus.iq_rs2_in == 5'd0) ? '0 : bus.reg_rs2_val_in;
        rs2_tag_q  <= (bus.iq_rs2_in == 5'd0) ? '0 : bus.reg_rs2_tag_in;
      end
    end
  end

  assign bus.issue_to_rs_en_out = issue_q;
  assign bus.rs_pos_out         = rs_pos_q;
  assign bus.rob_pos_out        = rob_pos_q;
  assign bus.instr_id_out       = instr_id_q;
  assign bus.imm_out            = imm_q;
  assign bus.pc_out             = pc_q;
  assign bus.rd_out             = rd_q;
  assign bus.rs1_reg_out        = rs1_val_q;
  assign bus.rs2_reg_out        = rs2_val_q;
  assign bus.rs1_tag_out        = rs1_tag_q;
  assign bus.rs2_tag_out        = rs2_tag_q;

endmodule

// File: tb/tb_rs_issue.sv
// Directed bench for rs_issue: expected issue records are queued when an
// instruction is presented and popped when the registered strobe appears.
module tb_rs_issue;

  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  rs_issue_if bus ();

  rs_issue dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.master)
  );

  typedef struct {
    logic [3:0]  rs_pos;
    logic [3:0]  rob_pos;
    logic [5:0]  instr_id;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] v1, v2;
    logic [3:0]  t1, t2;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // present an instruction on the IQ head with the regfile read data
  task automatic present(input logic [5:0] id, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [3:0] tag);
    bus.iq_valid_in     = 1'b1;
    bus.iq_instr_id_in  = id;
    bus.iq_imm_in       = 32'h1000_0000 | {26'd0, id};
    bus.iq_pc_in        = 32'h0000_4000 + {24'd0, id, 2'b00};
    bus.iq_rs1_in       = rs1;
    bus.iq_rs2_in       = rs2;
    bus.iq_rd_in        = rd;
    bus.rob_free_tag_in = tag;
    bus.reg_rs1_val_in  = 32'hA000_0000 | {27'd0, rs1};
    bus.reg_rs2_val_in  = 32'hB000_0000 | {27'd0, rs2};
    bus.reg_rs1_tag_in  = 4'd0;
    bus.reg_rs2_tag_in  = 4'd0;
  endtask

  // build the expected issue record from what the bench is driving
  task automatic push_exp(input logic [3:0] slot);
    exp_t e;
    e.rs_pos   = slot;
    e.rob_pos  = bus.rob_free_tag_in;
    e.instr_id = bus.iq_instr_id_in;
    e.imm      = bus.iq_imm_in;
    e.pc       = bus.iq_pc_in;
    e.rd       = bus.iq_rd_in;
    e.v1       = (bus.iq_rs1_in == 5'd0) ? 32'd0 : bus.reg_rs1_val_in;
    e.t1       = (bus.iq_rs1_in == 5'd0) ? 4'd0  : bus.reg_rs1_tag_in;
    e.v2       = (bus.iq_rs2_in == 5'd0) ? 32'd0 : bus.reg_rs2_val_in;
    e.t2       = (bus.iq_rs2_in == 5'd0) ? 4'd0  : bus.reg_rs2_tag_in;
    sb.push_back(e);
  endtask

  // compare the registered issue port against the scoreboard
  task automatic check_out(input string tag, input logic exp_en);
    exp_t e;
    chk({tag, ".issue_en"}, 64'(bus.issue_to_rs_en_out), 64'(exp_en));
    if (exp_en) begin
      if (sb.size() == 0) begin
        chk({tag, ".scoreboard_empty"}, 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, ".rs_pos"},   64'(bus.rs_pos_out),   64'(e.rs_pos));
        chk({tag, ".rob_pos"},  64'(bus.rob_pos_out),  64'(e.rob_pos));
        chk({tag, ".instr_id"}, 64'(bus.instr_id_out), 64'(e.instr_id));
        chk({tag, ".imm"},      64'(bus.imm_out),      64'(e.imm));
        chk({tag, ".pc"},       64'(bus.pc_out),       64'(e.pc));
        chk({tag, ".rd"},       64'(bus.rd_out),       64'(e.rd));
        chk({tag, ".rs1_val"},  64'(bus.rs1_reg_out),  64'(e.v1));
        chk({tag, ".rs1_tag"},  64'(bus.rs1_tag_out),  64'(e.t1));
        chk({tag, ".rs2_val"},  64'(bus.rs2_reg_out),  64'(e.v2));
        chk({tag, ".rs2_tag"},  64'(bus.rs2_tag_out),  64'(e.t2));
      end
    end
  endtask

  // combinational handshake check just before the next edge
  task automatic check_pop(input string tag, input logic exp_pop);
    chk({tag, ".iq_pop"},    64'(bus.iq_pop_out),       64'(exp_pop));
    chk({tag, ".rob_alloc"}, 64'(bus.rob_alloc_en_out), 64'(exp_pop));
  endtask

  initial begin
    // ---------------- reset (inputs would otherwise allow an accept) -------
    rst_in                = 1'b1;
    bus.rdy_in            = 1'b1;
    bus.clear_branch_in   = 1'b0;
    bus.rob_full_in       = 1'b0;
    bus.rs_busy_status_in = 16'h0000;
    present(6'd1, 5'd1, 5'd2, 5'd3, 4'd1);
    #2;
    check_pop("reset_comb", 1'b0);
    chk("reset_rename_en", 64'(bus.rename_en_out), 64'd0);
    tick();
    tick();
    check_out("reset", 1'b0);
    chk("reset_rs_pos", 64'(bus.rs_pos_out), 64'd0);
    check_pop("reset_comb2", 1'b0);

    rst_in          = 1'b0;
    bus.iq_valid_in = 1'b0;
    #1;
    check_pop("idle", 1'b0);
    tick();
    check_out("idle", 1'b0);

    // ---------------- three back-to-back issues, busy vector lagging -------
    present(6'd10, 5'd1, 5'd2, 5'd3, 4'd1);
    #1; check_pop("b2b0", 1'b1);
    chk("b2b0.rename_en",  64'(bus.rename_en_out),  64'd1);
    chk("b2b0.rename_rd",  64'(bus.rename_rd_out),  64'd3);
    chk("b2b0.rename_tag", 64'(bus.rename_tag_out), 64'd1);
    push_exp(4'd0);
    tick();
    check_out("b2b0", 1'b1);
    present(6'd11, 5'd3, 5'd4, 5'd5, 4'd2);           // busy still 0: slot 0 only masked
    #1; check_pop("b2b1", 1'b1);
    push_exp(4'd1);
    tick();
    check_out("b2b1", 1'b1);
    bus.rs_busy_status_in = 16'h0001;
    present(6'd12, 5'd5, 5'd6, 5'd7, 4'd3);
    #1; check_pop("b2b2", 1'b1);
    push_exp(4'd2);
    tick();
    check_out("b2b2", 1'b1);
    bus.rs_busy_status_in = 16'h0003;
    bus.iq_valid_in       = 1'b0;
    tick();
    check_out("b2b_drain", 1'b0);
    bus.rs_busy_status_in = 16'h0007;
    tick();

    // ---------------- last free slot (15), pending-mask stall --------------
    bus.rs_busy_status_in = 16'h7FFF;
    present(6'd20, 5'd1, 5'd2, 5'd9, 4'd4);
    #1; check_pop("last0", 1'b1);
    push_exp(4'd15);
    tick();
    check_out("last0", 1'b1);
    present(6'd21, 5'd2, 5'd3, 5'd10, 4'd5);          // slot 15 pending, busy lags
    #1; check_pop("last_stall", 1'b0);
    tick();
    check_out("last_stall", 1'b0);
    bus.rs_busy_status_in = 16'hFFFF;                 // RS now shows slot 15 busy
    #1; check_pop("last_full", 1'b0);
    tick();
    check_out("last_full", 1'b0);
    bus.rs_busy_status_in = 16'hFFF7;                 // RS frees slot 3
    #1; check_pop("last_free3", 1'b1);
    push_exp(4'd3);
    tick();
    check_out("last_free3", 1'b1);
    bus.iq_valid_in       = 1'b0;
    bus.rs_busy_status_in = 16'h0000;
    tick();
    check_out("last_drain", 1'b0);

    // ---------------- ROB full for 4 cycles --------------------------------
    bus.rob_full_in = 1'b1;
    present(6'd30, 5'd4, 5'd5, 5'd6, 4'd6);
    for (int i = 0; i < 4; i++) begin
      #1; check_pop("rob_full", 1'b0);
      tick();
      check_out("rob_full", 1'b0);
    end
    bus.rob_full_in = 1'b0;
    #1; check_pop("rob_release", 1'b1);
    push_exp(4'd0);
    tick();
    check_out("rob_release", 1'b1);
    bus.iq_valid_in = 1'b0;
    tick();
    check_out("rob_drain", 1'b0);

    // ---------------- x0 operands and rd=x0 --------------------------------
    present(6'd40, 5'd0, 5'd5, 5'd0, 4'd7);
    bus.reg_rs1_val_in = 32'h0000_1234;               // must be ignored for x0
    bus.reg_rs1_tag_in = 4'd7;
    bus.reg_rs2_val_in = 32'h0000_DEAD;
    bus.reg_rs2_tag_in = 4'd3;
    #1; check_pop("x0", 1'b1);
    chk("x0.rename_en", 64'(bus.rename_en_out), 64'd0);
    push_exp(4'd0);
    tick();
    check_out("x0", 1'b1);
    present(6'd41, 5'd8, 5'd9, 5'd7, 4'd8);
    bus.reg_rs1_tag_in = 4'd2;
    #1; check_pop("rename", 1'b1);
    chk("rename.en",  64'(bus.rename_en_out),  64'd1);
    chk("rename.rd",  64'(bus.rename_rd_out),  64'd7);
    chk("rename.tag", 64'(bus.rename_tag_out), 64'd8);
    push_exp(4'd1);                                   // slot 0 pending
    tick();
    check_out("rename", 1'b1);

    // ---------------- branch clear on an accept-eligible cycle -------------
    present(6'd50, 5'd1, 5'd2, 5'd3, 4'd9);
    bus.clear_branch_in = 1'b1;
    #1; check_pop("clear", 1'b0);
    chk("clear.rename_en", 64'(bus.rename_en_out), 64'd0);
    tick();
    check_out("clear", 1'b0);
    bus.clear_branch_in = 1'b0;

    // ---------------- rdy_in low freezes everything ------------------------
    present(6'd51, 5'd1, 5'd2, 5'd3, 4'd10);
    #1; check_pop("pre_stall", 1'b1);
    push_exp(4'd0);
    tick();
    check_out("pre_stall", 1'b1);
    push_exp(4'd0);                                   // same record expected while frozen
    push_exp(4'd0);
    bus.rdy_in = 1'b0;
    present(6'd52, 5'd4, 5'd5, 5'd6, 4'd11);          // new head must not be taken
    #1; check_pop("stall", 1'b0);
    tick();
    check_out("stall0", 1'b1);
    tick();
    check_out("stall1", 1'b1);
    bus.rdy_in      = 1'b1;
    bus.iq_valid_in = 1'b0;
    tick();
    check_out("unstall", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
